// File: rtl/security_controller.sv
// Access-code controller: programs the external code memory, compares entered codes,
// and sequences timed unlock and alarm lockout with a failed-attempt budget.
module security_controller #(
  parameter int unsigned MAX_TRIES      = 3,
  parameter int unsigned UNLOCK_CYCLES  = 8,
  parameter int unsigned LOCKOUT_CYCLES = 16,
  localparam int unsigned CODE_W        = 7,
  localparam int unsigned TRIES_W       = 3
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [CODE_W-1:0] code_in,
  input  logic              set_btn,
  input  logic              enter_btn,
  input  logic [CODE_W-1:0] mem_code,
  output logic [CODE_W-1:0] mem_data,
  output logic              mem_enable,
  output logic              armed,
  output logic              unlocked,
  output logic              alarm,
  output logic              error,
  output logic [TRIES_W-1:0] tries_left
);

  localparam int unsigned TIMER_W = 8;

  typedef enum logic [2:0] {
    UNSET   = 3'd0,
    PROGRAM = 3'd1,
    ARMED   = 3'd2,
    OPEN    = 3'd3,
    ALARM   = 3'd4
  } state_t;

  state_t               state, state_n;
  logic [CODE_W-1:0]    code_q, code_n;
  logic [TIMER_W-1:0]   timer, timer_n;
  logic [TRIES_W-1:0]   tries_n;
  logic                 error_n;

  // code_q is the latched code and doubles as the registered memory write data
  assign mem_data = code_q;

  // State, datapath registers and state-decoded registered outputs
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= UNSET;
      code_q     <= '0;
      timer      <= '0;
      tries_left <= TRIES_W'(MAX_TRIES);
      error      <= 1'b0;
      mem_enable <= 1'b0;
      armed      <= 1'b0;
      unlocked   <= 1'b0;
      alarm      <= 1'b0;
    end else begin
      state      <= state_n;
      code_q     <= code_n;
      timer      <= timer_n;
      tries_left <= tries_n;
      error      <= error_n;
      mem_enable <= (state_n == PROGRAM);
      armed      <= (state_n == ARMED);
      unlocked   <= (state_n == OPEN);
      alarm      <= (state_n == ALARM);
    end
  end

  // Next-state and datapath updates
  always_comb begin
    state_n = state;
    code_n  = code_q;
    timer_n = timer;
    tries_n = tries_left;
    error_n = 1'b0;
    unique case (state)
      UNSET: begin
        if (set_btn) begin
          code_n  = code_in;
          state_n = PROGRAM;
        end
      end
      PROGRAM: begin
        state_n = ARMED;
        tries_n = TRIES_W'(MAX_TRIES);
      end
      ARMED: begin
        // enter wins over a coincident set; set alone is ignored here
        if (enter_btn) begin
          if (code_in == mem_code) begin
            state_n = OPEN;
            timer_n = TIMER_W'(UNLOCK_CYCLES - 1);
            tries_n = TRIES_W'(MAX_TRIES);
          end else begin
            error_n = 1'b1;
            if (tries_left <= TRIES_W'(1)) begin
              state_n = ALARM;
              tries_n = '0;
              timer_n = TIMER_W'(LOCKOUT_CYCLES - 1);
            end else begin
              tries_n = tries_left - TRIES_W'(1);
            end
          end
        end
      end
      OPEN: begin
        // re-key takes precedence over timer expiry
        if (set_btn) begin
          code_n  = code_in;
          state_n = PROGRAM;
        end else if (timer == '0) begin
          state_n = ARMED;
        end else begin
          timer_n = timer - TIMER_W'(1);
        end
      end
      ALARM: begin
        if (timer == '0) begin
          state_n = ARMED;
          tries_n = TRIES_W'(MAX_TRIES);
        end else begin
          timer_n = timer - TIMER_W'(1);
        end
      end
      default: state_n = UNSET;
    endcase
  end

endmodule

// File: tb/tb_security_controller.sv
// Scoreboard bench for security_controller with a behavioural code memory.
module tb_security_controller;

  logic       clock;
  logic       reset_n;
  logic [6:0] code_in;
  logic       set_btn;
  logic       enter_btn;
  logic [6:0] mem_code;
  logic [6:0] mem_data;
  logic       mem_enable;
  logic       armed;
  logic       unlocked;
  logic       alarm;
  logic       error;
  logic [2:0] tries_left;

  int n_checks = 0;
  int n_fail   = 0;

  logic [14:0] exp_q[$];
  string       tag_q[$];
  logic [14:0] obs;

  security_controller dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .code_in    (code_in),
    .set_btn    (set_btn),
    .enter_btn  (enter_btn),
    .mem_code   (mem_code),
    .mem_data   (mem_data),
    .mem_enable (mem_enable),
    .armed      (armed),
    .unlocked   (unlocked),
    .alarm      (alarm),
    .error      (error),
    .tries_left (tries_left)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // External seven-bit code memory: not cleared by reset
  initial mem_code = 7'h00;
  always @(posedge clock) if (mem_enable) mem_code <= mem_data;

  assign obs = {mem_data, mem_enable, armed, unlocked, alarm, error, tries_left};

  function automatic logic [14:0] ex(input logic [6:0] md, input logic en, input logic a,
                                     input logic u, input logic al, input logic er,
                                     input logic [2:0] t);
    return {md, en, a, u, al, er, t};
  endfunction

  task automatic check(input string tag, input logic [14:0] act, input logic [14:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got md=%h en=%b arm=%b unl=%b alm=%b err=%b tries=%0d, want md=%h en=%b arm=%b unl=%b alm=%b err=%b tries=%0d",
               tag, act[14:8], act[7], act[6], act[5], act[4], act[3], act[2:0],
               expv[14:8], expv[7], expv[6], expv[5], expv[4], expv[3], expv[2:0]);
    end
  endtask

  // Drive one cycle of stimulus and queue the outputs expected after the next edge
  task automatic step(input logic s, input logic e, input logic [6:0] c, input string tag,
                      input logic [14:0] expv);
    @(negedge clock);
    set_btn   = s;
    enter_btn = e;
    code_in   = c;
    exp_q.push_back(expv);
    tag_q.push_back(tag);
  endtask

  task automatic idle(input string tag, input logic [14:0] expv);
    step(1'b0, 1'b0, 7'h00, tag, expv);
  endtask

  task automatic pulse_reset(input string tag);
    @(negedge clock);
    set_btn   = 1'b0;
    enter_btn = 1'b0;
    reset_n   = 1'b0;
    #1 check(tag, obs, ex(7'h00, 0, 0, 0, 0, 0, 3'd3));
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  always @(posedge clock) begin
    #1;
    if (exp_q.size() > 0) check(tag_q.pop_front(), obs, exp_q.pop_front());
  end

  initial begin
    reset_n   = 1'b0;
    set_btn   = 1'b0;
    enter_btn = 1'b0;
    code_in   = 7'h00;
    repeat (2) @(negedge clock);
    check("reset", obs, ex(7'h00, 0, 0, 0, 0, 0, 3'd3));
    @(negedge clock);
    reset_n = 1'b1;

    // Enter in UNSET does nothing, then program 5A
    step(0, 1, 7'h5A, "unset_enter", ex(7'h00, 0, 0, 0, 0, 0, 3'd3));
    step(1, 0, 7'h5A, "program",     ex(7'h5A, 1, 0, 0, 0, 0, 3'd3));
    idle("armed",                    ex(7'h5A, 0, 1, 0, 0, 0, 3'd3));

    // Match: 8 unlocked cycles then armed
    step(0, 1, 7'h5A, "match", ex(7'h5A, 0, 0, 1, 0, 0, 3'd3));
    for (int i = 0; i < 7; i++) idle("open_hold", ex(7'h5A, 0, 0, 1, 0, 0, 3'd3));
    idle("relock", ex(7'h5A, 0, 1, 0, 0, 0, 3'd3));

    // Lockout after three wrong entries
    step(0, 1, 7'h11, "miss1", ex(7'h5A, 0, 1, 0, 0, 1, 3'd2));
    idle("miss1_after",        ex(7'h5A, 0, 1, 0, 0, 0, 3'd2));
    step(0, 1, 7'h11, "miss2", ex(7'h5A, 0, 1, 0, 0, 1, 3'd1));
    idle("miss2_after",        ex(7'h5A, 0, 1, 0, 0, 0, 3'd1));
    step(0, 1, 7'h11, "miss3", ex(7'h5A, 0, 0, 0, 1, 1, 3'd0));
    step(0, 1, 7'h5A, "alarm_ignore", ex(7'h5A, 0, 0, 0, 1, 0, 3'd0));
    for (int i = 0; i < 14; i++) idle("alarm_hold", ex(7'h5A, 0, 0, 0, 1, 0, 3'd0));
    idle("alarm_end", ex(7'h5A, 0, 1, 0, 0, 0, 3'd3));

    // Re-key from OPEN to 03
    step(0, 1, 7'h5A, "rk_open", ex(7'h5A, 0, 0, 1, 0, 0, 3'd3));
    idle("rk_hold",              ex(7'h5A, 0, 0, 1, 0, 0, 3'd3));
    step(1, 0, 7'h03, "rk_prog", ex(7'h03, 1, 0, 0, 0, 0, 3'd3));
    idle("rk_armed",             ex(7'h03, 0, 1, 0, 0, 0, 3'd3));
    step(0, 1, 7'h5A, "rk_old",  ex(7'h03, 0, 1, 0, 0, 1, 3'd2));
    step(0, 1, 7'h03, "rk_new",  ex(7'h03, 0, 0, 1, 0, 0, 3'd3));
    for (int i = 0; i < 7; i++) idle("rk_new_hold", ex(7'h03, 0, 0, 1, 0, 0, 3'd3));
    // set on the expiry cycle still re-keys
    step(1, 0, 7'h5A, "rk_expiry", ex(7'h5A, 1, 0, 0, 0, 0, 3'd3));
    idle("rk_expiry_armed",        ex(7'h5A, 0, 1, 0, 0, 0, 3'd3));

    // Simultaneous buttons: enter wins, no write
    step(1, 1, 7'h5A, "both", ex(7'h5A, 0, 0, 1, 0, 0, 3'd3));
    for (int i = 0; i < 7; i++) idle("both_hold", ex(7'h5A, 0, 0, 1, 0, 0, 3'd3));
    idle("both_relock", ex(7'h5A, 0, 1, 0, 0, 0, 3'd3));
    step(1, 0, 7'h22, "set_in_armed", ex(7'h5A, 0, 1, 0, 0, 0, 3'd3));
    idle("set_in_armed_after",        ex(7'h5A, 0, 1, 0, 0, 0, 3'd3));

    // Reset during PROGRAM
    step(0, 1, 7'h5A, "pre_rst_open", ex(7'h5A, 0, 0, 1, 0, 0, 3'd3));
    step(1, 0, 7'h44, "pre_rst_prog", ex(7'h44, 1, 0, 0, 0, 0, 3'd3));
    pulse_reset("reset_in_program");
    step(0, 1, 7'h5A, "unset_enter2", ex(7'h00, 0, 0, 0, 0, 0, 3'd3));

    // Reprogram, drive into ALARM, reset there
    step(1, 0, 7'h5A, "reprog",  ex(7'h5A, 1, 0, 0, 0, 0, 3'd3));
    idle("reprog_armed",         ex(7'h5A, 0, 1, 0, 0, 0, 3'd3));
    step(0, 1, 7'h11, "rm1",     ex(7'h5A, 0, 1, 0, 0, 1, 3'd2));
    step(0, 1, 7'h12, "rm2",     ex(7'h5A, 0, 1, 0, 0, 1, 3'd1));
    step(0, 1, 7'h13, "rm3",     ex(7'h5A, 0, 0, 0, 1, 1, 3'd0));
    idle("rm_alarm",             ex(7'h5A, 0, 0, 0, 1, 0, 3'd0));
    pulse_reset("reset_in_alarm");
    step(0, 1, 7'h5A, "unset_enter3", ex(7'h00, 0, 0, 0, 0, 0, 3'd3));
    idle("unset_idle",                ex(7'h00, 0, 0, 0, 0, 0, 3'd3));

    @(negedge clock);
    @(negedge clock);
    check("drain", 15'(exp_q.size()), 15'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
